// File: rtl/arm_pipe_pkg.sv
// ============================================================================
// Module : arm_pipe_pkg
// Brief  : Shared pipeline types, default widths and skid-buffer state codes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_pipe_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 4;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    typedef struct packed {
        logic                      wb_en;
        logic                      mem_r_en;
        logic [DEF_DATA_W-1:0]     alu_res;
        logic [DEF_DATA_W-1:0]     mem_data;
        logic [DEF_REG_ADDR_W-1:0] dest;
    } wb_payload_t;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_buf.sv
// ============================================================================
// Module : pipe_skid_buf
// Brief  : Generic 2-entry valid/ready skid buffer; in_ready comes from state only.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_buf
    import arm_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [W-1:0] skid_data,
    output logic [1:0]   state
);

    logic [1:0]   state_reg;
    logic [W-1:0] main_reg;
    logic [W-1:0] skid_reg;
    logic         in_fire;
    logic         out_fire;

    assign in_ready  = (state_reg != ST_FULL);
    assign out_valid = (state_reg != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = main_reg;
    assign skid_data = skid_reg;
    assign state     = state_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else if (flush) begin
            // Payload is left untouched; only occupancy is dropped.
            state_reg <= ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_reg <= ST_ONE;
                        main_reg  <= in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_reg <= in_data;
                    end else if (in_fire) begin
                        state_reg <= ST_FULL;
                        skid_reg  <= in_data;
                    end else if (out_fire) begin
                        state_reg <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_reg <= ST_ONE;
                        main_reg  <= skid_reg;
                    end
                end
                default: state_reg <= ST_EMPTY;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_wb_pipe_stage.sv
// ============================================================================
// Module : mem_wb_pipe_stage
// Brief  : MEM->WB stage: skid-buffered writeback payload, flush, stall counter.
//          Optional forwarding taps enabled by defining MEM_WB_FWD_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_pipe_stage
    import arm_pipe_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_wb_en,
    input  logic                   in_mem_r_en,
    input  logic [DATA_W-1:0]      in_alu_res,
    input  logic [DATA_W-1:0]      in_mem_data,
    input  logic [REG_ADDR_W-1:0]  in_dest,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_wb_en,
    output logic [REG_ADDR_W-1:0]  out_dest,
    output logic [DATA_W-1:0]      out_wb_value,
    output logic [STALL_CNT_W-1:0] stall_cycles
`ifdef MEM_WB_FWD_EN
    ,
    output logic                   fwd_valid,
    output logic [REG_ADDR_W-1:0]  fwd_dest,
    output logic [DATA_W-1:0]      fwd_value,
    output logic                   fwd2_valid,
    output logic [REG_ADDR_W-1:0]  fwd2_dest,
    output logic [DATA_W-1:0]      fwd2_value
`endif
);

    localparam int PAY_W = 1 + REG_ADDR_W + DATA_W;

    logic [PAY_W-1:0]       in_pay;
    logic [PAY_W-1:0]       main_pay;
    logic [PAY_W-1:0]       skid_pay;
    logic [1:0]             buf_state;
    logic [STALL_CNT_W-1:0] stall_reg;

    // Value select happens before capture so the output value is a plain flop.
    assign in_pay = {in_wb_en, in_dest, (in_mem_r_en ? in_mem_data : in_alu_res)};

    pipe_skid_buf #(
        .W(PAY_W)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (main_pay),
        .skid_data (skid_pay),
        .state     (buf_state)
    );

    assign out_wb_en    = out_valid & main_pay[PAY_W-1];
    assign out_dest     = main_pay[DATA_W +: REG_ADDR_W];
    assign out_wb_value = main_pay[DATA_W-1:0];
    assign stall_cycles = stall_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_reg <= '0;
        end else if (out_valid && !out_ready && !(&stall_reg)) begin
            stall_reg <= stall_reg + 1'b1;
        end
    end

`ifdef MEM_WB_FWD_EN
    assign fwd_valid  = out_wb_en;
    assign fwd_dest   = out_dest;
    assign fwd_value  = out_wb_value;
    assign fwd2_valid = (buf_state == ST_FULL) & skid_pay[PAY_W-1];
    assign fwd2_dest  = skid_pay[DATA_W +: REG_ADDR_W];
    assign fwd2_value = skid_pay[DATA_W-1:0];
`else
    logic unused_fwd_taps;
    assign unused_fwd_taps = ^{skid_pay, buf_state};
`endif

endmodule

`default_nettype wire
